synth_key_scheduler: RTL

- Converts the raw PS/2 scan-byte stream into synth control state and schedules notes onto a fixed pool of polyphonic voices.
- Handles make codes, break codes (F0 prefix) and extended prefixes (E0).
- Maintains the global octave register and the 5-entry ADSR/volume parameter file.
- Sits between the PS/2 receiver and the voice/oscillator bank; replaces single-note, single-cycle decoding with stateful gate-on/gate-off control.

---
 rtl/synth_key_scheduler.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/synth_key_scheduler.sv
// ---------------------------------------------------------------------------
// synth_key_scheduler
//
// Purpose:
//   Turns the raw PS/2 scan-byte stream into synthesizer control state.
//   It decodes make/break/extended prefixes, drives gate-on/gate-off for a
//   fixed pool of polyphonic voices, and keeps the global octave and the
//   five-entry volume/ADSR parameter file.
//
// Ports:
//   CLOCK_50      in   system clock, rising edge
//   reset         in   synchronous active-high reset
//   scan_code     in   [7:0] byte from the PS/2 receiver
//   scan_valid    in   one-cycle strobe qualifying scan_code
//   voice_gate    out  [NUM_VOICES-1:0] gate per voice (1 = key held)
//   voice_note    out  [4*NUM_VOICES-1:0] note 0..11, voice i at [4i+3:4i]
//   voice_octave  out  [3*NUM_VOICES-1:0] octave latched at allocation
//   octave        out  [2:0] current global octave
//   adsr_sel      out  [2:0] selected parameter (0 vol, 1 A, 2 D, 3 S, 4 R)
//   adsr_params   out  [19:0] parameter file, entry k at [4k+3:4k]
//   steal_evt     out  one-cycle pulse when a held voice is stolen
// ---------------------------------------------------------------------------
module synth_key_scheduler #(
  parameter int NUM_VOICES    = 4,
  parameter int OCT_DEFAULT   = 4,
  parameter int PARAM_DEFAULT = 8
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic [7:0]              scan_code,
  input  logic                    scan_valid,
  output logic [NUM_VOICES-1:0]   voice_gate,
  output logic [4*NUM_VOICES-1:0] voice_note,
  output logic [3*NUM_VOICES-1:0] voice_octave,
  output logic [2:0]              octave,
  output logic [2:0]              adsr_sel,
  output logic [19:0]             adsr_params,
  output logic                    steal_evt
);

  localparam int PTR_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_VOICES - 1);

  localparam logic [7:0] CODE_BRK = 8'hF0;
  localparam logic [7:0] CODE_EXT = 8'hE0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } state_t;

  typedef enum logic [2:0] {
    CTL_NONE,
    CTL_OCT_DN,
    CTL_OCT_UP,
    CTL_SEL,
    CTL_MINUS,
    CTL_PLUS
  } ctrl_t;

  state_t           r_state;
  logic [3:0]       r_voiceNote [NUM_VOICES];
  logic [2:0]       r_voiceOct  [NUM_VOICES];
  logic [NUM_VOICES-1:0] r_voiceGate;
  logic [2:0]       r_octave;
  logic [2:0]       r_adsrSel;
  logic [3:0]       r_params [5];
  logic             r_stealEvt;
  logic [PTR_W-1:0] r_stealPtr;

  logic             w_isNote;
  logic [3:0]       w_noteVal;
  ctrl_t            w_ctrl;
  logic [2:0]       w_selVal;
  logic             w_heldHit;
  logic [PTR_W-1:0] w_heldIdx;
  logic             w_freeFound;
  logic [PTR_W-1:0] w_freeIdx;
  logic             w_makeEvt;
  logic             w_breakEvt;

  // Key map: classify the current byte as a note, a control, or nothing.
  always_comb begin
    w_isNote  = 1'b0;
    w_noteVal = 4'd0;
    w_ctrl    = CTL_NONE;
    w_selVal  = 3'd0;
    case (scan_code)
      8'h1C: begin w_isNote = 1'b1; w_noteVal = 4'd0;  end
      8'h1D: begin w_isNote = 1'b1; w_noteVal = 4'd1;  end
      8'h1B: begin w_isNote = 1'b1; w_noteVal = 4'd2;  end
      8'h24: begin w_isNote = 1'b1; w_noteVal = 4'd3;  end
      8'h23: begin w_isNote = 1'b1; w_noteVal = 4'd4;  end
      8'h2B: begin w_isNote = 1'b1; w_noteVal = 4'd5;  end
      8'h2C: begin w_isNote = 1'b1; w_noteVal = 4'd6;  end
      8'h34: begin w_isNote = 1'b1; w_noteVal = 4'd7;  end
      8'h35: begin w_isNote = 1'b1; w_noteVal = 4'd8;  end
      8'h33: begin w_isNote = 1'b1; w_noteVal = 4'd9;  end
      8'h3C: begin w_isNote = 1'b1; w_noteVal = 4'd10; end
      8'h3B: begin w_isNote = 1'b1; w_noteVal = 4'd11; end
      8'h1A: w_ctrl = CTL_OCT_DN;
      8'h22: w_ctrl = CTL_OCT_UP;
      8'h16: begin w_ctrl = CTL_SEL; w_selVal = 3'd0; end
      8'h1E: begin w_ctrl = CTL_SEL; w_selVal = 3'd1; end
      8'h26: begin w_ctrl = CTL_SEL; w_selVal = 3'd2; end
      8'h25: begin w_ctrl = CTL_SEL; w_selVal = 3'd3; end
      8'h2E: begin w_ctrl = CTL_SEL; w_selVal = 3'd4; end
      8'h21: w_ctrl = CTL_MINUS;
      8'h2A: w_ctrl = CTL_PLUS;
      default: ;
    endcase
  end

  // Voice search: which gated voice already holds this note, and which is
  // the lowest-index free voice. Scanning downward lets the lowest index win.
  always_comb begin
    w_heldHit   = 1'b0;
    w_heldIdx   = '0;
    w_freeFound = 1'b0;
    w_freeIdx   = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (r_voiceGate[i] && (r_voiceNote[i] == w_noteVal)) begin
        w_heldHit = 1'b1;
        w_heldIdx = PTR_W'(i);
      end
      if (!r_voiceGate[i]) begin
        w_freeFound = 1'b1;
        w_freeIdx   = PTR_W'(i);
      end
    end
  end

  // A make is any non-prefix byte seen in IDLE; a break is any non-E0 byte
  // seen directly after F0. Extended sequences never produce an event.
  assign w_makeEvt  = scan_valid && (r_state == ST_IDLE) &&
                      (scan_code != CODE_BRK) && (scan_code != CODE_EXT);
  assign w_breakEvt = scan_valid && (r_state == ST_BRK) &&
                      (scan_code != CODE_EXT);

  // Prefix FSM plus all registered control state. Reset wins over any byte
  // and also drops a half-received prefix.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_voiceGate <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_voiceNote[i] <= 4'd0;
        r_voiceOct[i]  <= 3'd0;
      end
      r_octave   <= 3'(OCT_DEFAULT);
      r_adsrSel  <= 3'd0;
      for (int k = 0; k < 5; k++) begin
        r_params[k] <= 4'(PARAM_DEFAULT);
      end
      r_stealEvt <= 1'b0;
      r_stealPtr <= '0;
    end else begin
      r_stealEvt <= 1'b0;

      if (scan_valid) begin
        case (r_state)
          ST_IDLE: begin
            if (scan_code == CODE_BRK)      r_state <= ST_BRK;
            else if (scan_code == CODE_EXT) r_state <= ST_EXT;
            else                            r_state <= ST_IDLE;
          end
          ST_BRK: begin
            if (scan_code == CODE_EXT) r_state <= ST_EXT_BRK;
            else                       r_state <= ST_IDLE;
          end
          ST_EXT: begin
            if (scan_code == CODE_BRK) r_state <= ST_EXT_BRK;
            else                       r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end

      if (w_makeEvt) begin
        if (w_isNote) begin
          // A note already sounding absorbs typematic repeats untouched.
          if (!w_heldHit) begin
            if (w_freeFound) begin
              r_voiceGate[w_freeIdx] <= 1'b1;
              r_voiceNote[w_freeIdx] <= w_noteVal;
              r_voiceOct[w_freeIdx]  <= r_octave;
            end else begin
              r_voiceGate[r_stealPtr] <= 1'b1;
              r_voiceNote[r_stealPtr] <= w_noteVal;
              r_voiceOct[r_stealPtr]  <= r_octave;
              r_stealEvt              <= 1'b1;
              r_stealPtr <= (r_stealPtr == PTR_LAST) ? '0 : r_stealPtr + 1'b1;
            end
          end
        end else begin
          case (w_ctrl)
            CTL_OCT_DN: if (r_octave != 3'd0) r_octave <= r_octave - 3'd1;
            CTL_OCT_UP: if (r_octave != 3'd7) r_octave <= r_octave + 3'd1;
            CTL_SEL:    r_adsrSel <= w_selVal;
            CTL_MINUS:  if (r_params[r_adsrSel] != 4'd0)
                          r_params[r_adsrSel] <= r_params[r_adsrSel] - 4'd1;
            CTL_PLUS:   if (r_params[r_adsrSel] != 4'd15)
                          r_params[r_adsrSel] <= r_params[r_adsrSel] + 4'd1;
            default: ;
          endcase
        end
      end

      // Break only drops the gate; note and octave stay for the release tail.
      if (w_breakEvt && w_isNote && w_heldHit) begin
        r_voiceGate[w_heldIdx] <= 1'b0;
      end
    end
  end

  // Flatten the per-voice and per-parameter registers onto the output buses.
  genvar gv;
  generate
    for (gv = 0; gv < NUM_VOICES; gv++) begin : g_voiceOut
      assign voice_note[4*gv +: 4]   = r_voiceNote[gv];
      assign voice_octave[3*gv +: 3] = r_voiceOct[gv];
    end
    for (gv = 0; gv < 5; gv++) begin : g_paramOut
      assign adsr_params[4*gv +: 4] = r_params[gv];
    end
  endgenerate

  assign voice_gate = r_voiceGate;
  assign octave     = r_octave;
  assign adsr_sel   = r_adsrSel;
  assign steal_evt  = r_stealEvt;

endmodule
